// File: rtl/pad_mask_gen_if.sv
// pad_mask_gen_if: config handshake, beat strobe and mask/position outputs of pad_mask_gen
interface pad_mask_gen_if #(
   parameter int KERNEL_W_MAX = 7,
   parameter int KERNEL_H_MAX = 7,
   parameter int COLS_WIDTH   = 10,
   parameter int ROWS_WIDTH   = 10
);
   localparam int KWW = $clog2(KERNEL_W_MAX + 1);
   localparam int KHW = $clog2(KERNEL_H_MAX + 1);
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [KWW-1:0]          cfg_kw_1;
   logic [KHW-1:0]          cfg_kh_1;
   logic [COLS_WIDTH-1:0]   cfg_cols_1;
   logic [ROWS_WIDTH-1:0]   cfg_rows_1;
   logic                    cfg_same;
   logic                    beat_valid;
   logic [KERNEL_W_MAX-1:0] mask_col;
   logic [KERNEL_H_MAX-1:0] mask_row;
   logic [COLS_WIDTH-1:0]   pos_col;
   logic [ROWS_WIDTH-1:0]   pos_row;
   logic                    frame_last;
   logic                    busy;
   logic                    cfg_err;
   modport master (
      output cfg_valid, cfg_kw_1, cfg_kh_1, cfg_cols_1, cfg_rows_1, cfg_same, beat_valid,
      input  cfg_ready, mask_col, mask_row, pos_col, pos_row, frame_last, busy, cfg_err
   );
   modport slave (
      input  cfg_valid, cfg_kw_1, cfg_kh_1, cfg_cols_1, cfg_rows_1, cfg_same, beat_valid,
      output cfg_ready, mask_col, mask_row, pos_col, pos_row, frame_last, busy, cfg_err
   );
endinterface

// File: rtl/pad_mask_gen.sv
// pad_mask_gen: walks output positions of a frame and emits per-tap padding masks
module pad_mask_gen #(
   parameter int KERNEL_W_MAX = 7,
   parameter int KERNEL_H_MAX = 7,
   parameter int COLS_WIDTH   = 10,
   parameter int ROWS_WIDTH   = 10
) (
   input logic           aclk,
   input logic           areset,
   input logic           aclken,
   pad_mask_gen_if.slave s
);
   localparam int KWW = $clog2(KERNEL_W_MAX + 1);
   localparam int KHW = $clog2(KERNEL_H_MAX + 1);
   localparam int CX  = COLS_WIDTH + KWW + 1;
   localparam int RX  = ROWS_WIDTH + KHW + 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t                  state;
   logic [KWW-1:0]          kw_1;
   logic [KHW-1:0]          kh_1;
   logic [COLS_WIDTH-1:0]   cols_1, pos_col, last_col;
   logic [ROWS_WIDTH-1:0]   rows_1, pos_row, last_row;
   logic                    same, cfg_err, illegal, run, col_end, frame_last;
   logic [KERNEL_W_MAX-1:0] mc;
   logic [KERNEL_H_MAX-1:0] mr;
   // Legal kernels have even kw_1/kh_1, so 2*(k_1>>1) equals k_1 for the valid-mode fit test
   assign illegal = s.cfg_kw_1[0] | s.cfg_kh_1[0]
                  | (s.cfg_kw_1 > KWW'(KERNEL_W_MAX - 1)) | (s.cfg_kh_1 > KHW'(KERNEL_H_MAX - 1))
                  | (~s.cfg_same & ((CX'(s.cfg_cols_1) < CX'(s.cfg_kw_1)) | (RX'(s.cfg_rows_1) < RX'(s.cfg_kh_1))));
   assign last_col   = same ? cols_1 : cols_1 - COLS_WIDTH'(kw_1);
   assign last_row   = same ? rows_1 : rows_1 - ROWS_WIDTH'(kh_1);
   assign run        = state == RUN;
   assign col_end    = pos_col == last_col;
   assign frame_last = run & col_end & (pos_row == last_row);
   for (genvar c = 0; c < KERNEL_W_MAX; c++) begin : g_col
      logic [CX-1:0] t;
      assign t     = CX'(pos_col) + CX'(c);
      assign mc[c] = run & (kw_1 >= KWW'(c))
                   & (~same | ((t >= CX'(kw_1 >> 1)) & (t <= CX'(cols_1) + CX'(kw_1 >> 1))));
   end
   for (genvar r = 0; r < KERNEL_H_MAX; r++) begin : g_row
      logic [RX-1:0] t;
      assign t     = RX'(pos_row) + RX'(r);
      assign mr[r] = run & (kh_1 >= KHW'(r))
                   & (~same | ((t >= RX'(kh_1 >> 1)) & (t <= RX'(rows_1) + RX'(kh_1 >> 1))));
   end
   assign s.mask_col   = mc;
   assign s.mask_row   = mr;
   assign s.pos_col    = pos_col;
   assign s.pos_row    = pos_row;
   assign s.frame_last = frame_last;
   assign s.busy       = run;
   assign s.cfg_ready  = ~run;
   assign s.cfg_err    = cfg_err;
   // Config acceptance, raster walk over output positions and sticky illegal-config flag
   always_ff @(posedge aclk) begin
      if (areset) begin
         state   <= IDLE;
         cfg_err <= 1'b0;
         kw_1    <= '0;
         kh_1    <= '0;
         cols_1  <= '0;
         rows_1  <= '0;
         same    <= 1'b0;
         pos_col <= '0;
         pos_row <= '0;
      end else if (aclken) begin
         if (state == IDLE) begin
            if (s.cfg_valid) begin
               cfg_err <= illegal;
               if (!illegal) begin
                  state   <= RUN;
                  kw_1    <= s.cfg_kw_1;
                  kh_1    <= s.cfg_kh_1;
                  cols_1  <= s.cfg_cols_1;
                  rows_1  <= s.cfg_rows_1;
                  same    <= s.cfg_same;
                  pos_col <= '0;
                  pos_row <= '0;
               end
            end
         end else if (s.beat_valid) begin
            pos_col <= col_end ? '0 : pos_col + 1'b1;
            pos_row <= frame_last ? '0 : col_end ? pos_row + 1'b1 : pos_row;
            if (frame_last) state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_pad_mask_gen.sv
// tb_pad_mask_gen: directed and random frames checked against a beat-count reference model
module tb_pad_mask_gen;
   localparam int KW = 7;
   localparam int KH = 7;
   localparam int CW = 10;
   localparam int RW = 10;
   logic aclk = 1'b0;
   logic areset = 1'b1;
   logic aclken = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;
   bit   m_busy, m_err, m_same;
   int   m_kw_1, m_kh_1, m_cols_1, m_rows_1, m_k;

   pad_mask_gen_if #(.KERNEL_W_MAX(KW), .KERNEL_H_MAX(KH), .COLS_WIDTH(CW), .ROWS_WIDTH(RW)) bus ();
   pad_mask_gen #(.KERNEL_W_MAX(KW), .KERNEL_H_MAX(KH), .COLS_WIDTH(CW), .ROWS_WIDTH(RW)) dut (
      .aclk(aclk), .areset(areset), .aclken(aclken), .s(bus)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   function automatic bit legal(input int kw_1, input int kh_1, input int cols_1, input int rows_1, input bit same);
      if (kw_1 % 2 != 0 || kh_1 % 2 != 0 || kw_1 > KW - 1 || kh_1 > KH - 1) return 1'b0;
      if (!same && (cols_1 < 2 * (kw_1 / 2) || rows_1 < 2 * (kh_1 / 2))) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int ncols();
      return m_same ? m_cols_1 + 1 : m_cols_1 + 1 - 2 * (m_kw_1 / 2);
   endfunction

   function automatic int nrows();
      return m_same ? m_rows_1 + 1 : m_rows_1 + 1 - 2 * (m_kh_1 / 2);
   endfunction

   function automatic logic [KW-1:0] exp_mask(input int n, input int k_1, input int pos, input int lim);
      logic [KW-1:0] m;
      int p;
      m = '0;
      for (int j = 0; j < n; j++) begin
         p = pos - k_1 / 2 + j;
         m[j] = m_busy && j <= k_1 && (!m_same || (p >= 0 && p <= lim));
      end
      return m;
   endfunction

   // Reference: a frame is just a beat count k over ncols*nrows positions
   always @(posedge aclk) begin
      if (areset) begin
         m_busy <= 1'b0; m_err <= 1'b0; m_k <= 0; m_same <= 1'b0;
         m_kw_1 <= 0; m_kh_1 <= 0; m_cols_1 <= 0; m_rows_1 <= 0;
      end else if (aclken) begin
         if (!m_busy) begin
            if (bus.cfg_valid) begin
               if (legal(int'(bus.cfg_kw_1), int'(bus.cfg_kh_1), int'(bus.cfg_cols_1), int'(bus.cfg_rows_1), bus.cfg_same)) begin
                  m_busy <= 1'b1; m_err <= 1'b0; m_k <= 0;
                  m_kw_1 <= int'(bus.cfg_kw_1); m_kh_1 <= int'(bus.cfg_kh_1);
                  m_cols_1 <= int'(bus.cfg_cols_1); m_rows_1 <= int'(bus.cfg_rows_1);
                  m_same <= bus.cfg_same;
               end else m_err <= 1'b1;
            end
         end else if (bus.beat_valid) begin
            if (m_k == ncols() * nrows() - 1) begin
               m_busy <= 1'b0; m_k <= 0;
            end else m_k <= m_k + 1;
         end
      end
   end

   // Every cycle, compare all outputs against the model
   always @(negedge aclk) begin
      int c, r;
      if (chk_en) begin
         c = m_busy ? m_k % ncols() : 0;
         r = m_busy ? m_k / ncols() : 0;
         chk("busy", bus.busy, m_busy);
         chk("cfg_ready", bus.cfg_ready, !m_busy);
         chk("cfg_err", bus.cfg_err, m_err);
         chk("pos_col", bus.pos_col, c);
         chk("pos_row", bus.pos_row, r);
         chk("mask_col", bus.mask_col, exp_mask(KW, m_kw_1, c, m_cols_1));
         chk("mask_row", bus.mask_row, exp_mask(KH, m_kh_1, r, m_rows_1));
         chk("frame_last", bus.frame_last, m_busy && m_k == ncols() * nrows() - 1);
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic send_cfg(input int kw_1, input int kh_1, input int cols_1, input int rows_1, input bit same);
      bus.cfg_kw_1 = 3'(kw_1);
      bus.cfg_kh_1 = 3'(kh_1);
      bus.cfg_cols_1 = 10'(cols_1);
      bus.cfg_rows_1 = 10'(rows_1);
      bus.cfg_same = same;
      bus.cfg_valid = 1'b1;
      tick();
      bus.cfg_valid = 1'b0;
   endtask

   task automatic beat();
      bus.beat_valid = 1'b1;
      tick();
      bus.beat_valid = 1'b0;
   endtask

   initial begin
      int budget;
      bus.cfg_valid = 1'b0; bus.beat_valid = 1'b0; bus.cfg_same = 1'b0;
      bus.cfg_kw_1 = '0; bus.cfg_kh_1 = '0; bus.cfg_cols_1 = '0; bus.cfg_rows_1 = '0;
      tick();
      chk_en = 1'b1;
      tick();
      areset = 1'b0;
      chk("rst_ready", bus.cfg_ready, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_masks", {bus.mask_col, bus.mask_row}, 14'd0);
      // Same mode 5x3 kernel on a 5x3 image
      send_cfg(4, 2, 4, 2, 1'b1);
      chk("same_mc0", bus.mask_col, 7'b0011100);
      chk("same_mr0", bus.mask_row, 7'b0000110);
      for (int i = 0; i < 14; i++) beat();
      chk("same_pos_end", {bus.pos_row, bus.pos_col}, {10'd2, 10'd4});
      chk("same_mc_end", bus.mask_col, 7'b0000111);
      chk("same_mr_end", bus.mask_row, 7'b0000011);
      chk("same_last", bus.frame_last, 1'b1);
      beat();
      chk("same_idle", bus.busy, 1'b0);
      // Valid mode: 4x2 output positions
      send_cfg(2, 2, 5, 3, 1'b0);
      for (int i = 0; i < 7; i++) begin
         chk("valid_mc", bus.mask_col, 7'b0000111);
         chk("valid_not_last", bus.frame_last, 1'b0);
         beat();
      end
      chk("valid_last", bus.frame_last, 1'b1);
      chk("valid_pos_end", {bus.pos_row, bus.pos_col}, {10'd1, 10'd3});
      beat();
      chk("valid_idle", bus.busy, 1'b0);
      // Even kernel is rejected, then a legal one clears the flag
      send_cfg(3, 0, 4, 4, 1'b1);
      chk("err_set", bus.cfg_err, 1'b1);
      chk("err_idle", bus.busy, 1'b0);
      send_cfg(0, 0, 1, 1, 1'b1);
      chk("err_clr", bus.cfg_err, 1'b0);
      chk("err_run", bus.busy, 1'b1);
      // Config offered mid-frame must be ignored
      bus.cfg_kw_1 = 3'd2; bus.cfg_cols_1 = 10'd9; bus.cfg_valid = 1'b1;
      beat();
      beat();
      bus.cfg_valid = 1'b0;
      chk("midcfg_pos", {bus.pos_row, bus.pos_col}, {10'd1, 10'd0});
      chk("midcfg_mc", bus.mask_col, 7'b0000001);
      beat();
      beat();
      chk("midcfg_idle", bus.busy, 1'b0);
      // 1x1 kernel on a 1x1 image
      send_cfg(0, 0, 0, 0, 1'b1);
      chk("one_mc", bus.mask_col, 7'b0000001);
      chk("one_mr", bus.mask_row, 7'b0000001);
      chk("one_last", bus.frame_last, 1'b1);
      beat();
      chk("one_idle", bus.busy, 1'b0);
      // Reset mid-frame, then clock-enable freeze
      send_cfg(2, 2, 4, 4, 1'b1);
      for (int i = 0; i < 7; i++) beat();
      chk("rst_mid_pos", {bus.pos_row, bus.pos_col}, {10'd1, 10'd2});
      areset = 1'b1; aclken = 1'b0;
      tick();
      areset = 1'b0; aclken = 1'b1;
      chk("rst_mid_idle", bus.busy, 1'b0);
      chk("rst_mid_pos0", {bus.pos_row, bus.pos_col}, 20'd0);
      chk("rst_mid_masks", {bus.mask_col, bus.mask_row}, 14'd0);
      beat();
      chk("rst_beat_ignored", bus.busy, 1'b0);
      send_cfg(2, 2, 4, 4, 1'b1);
      for (int i = 0; i < 3; i++) beat();
      aclken = 1'b0; bus.beat_valid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("freeze_col", bus.pos_col, 10'd3);
      aclken = 1'b1; bus.beat_valid = 1'b0;
      areset = 1'b1;
      tick();
      areset = 1'b0;
      // Random frames with random enables, beats, stray configs and rare resets
      for (int it = 0; it < 60; it++) begin
         send_cfg($urandom_range(0, 3) * 2 + ($urandom_range(0, 7) == 0 ? 1 : 0), $urandom_range(0, 3) * 2,
                  $urandom_range(0, 12), $urandom_range(0, 8), 1'($urandom_range(0, 1)));
         budget = 0;
         while (m_busy && budget < 3000) begin
            aclken = $urandom_range(0, 7) != 0;
            bus.beat_valid = $urandom_range(0, 3) != 0;
            bus.cfg_valid = $urandom_range(0, 9) == 0;
            bus.cfg_kw_1 = 3'($urandom_range(0, 7));
            bus.cfg_cols_1 = 10'($urandom_range(0, 12));
            areset = $urandom_range(0, 499) == 0;
            tick();
            budget++;
         end
         aclken = 1'b1; bus.beat_valid = 1'b0; bus.cfg_valid = 1'b0; areset = 1'b0;
         checks++;
         if (budget >= 3000) begin
            errors++;
            $display("FAIL frame_timeout: frame %0d still busy after %0d cycles, required idle", it, budget);
         end
      end
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
